// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result FIFOs with round-robin broadcast onto the common data bus
module cdb_arbiter #(
   parameter int DEPTH         = 4,
   parameter int ROB_IDX_BITS  = 6,
   parameter int PHYS_REG_BITS = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_add_valid,
   input  logic [ROB_IDX_BITS-1:0]  in_add_rob_idx,
   input  logic [PHYS_REG_BITS-1:0] in_add_pd_s,
   input  logic [4:0]               in_add_rd_s,
   input  logic [31:0]              in_add_rd_v,
   input  logic                     in_mul_valid,
   input  logic [ROB_IDX_BITS-1:0]  in_mul_rob_idx,
   input  logic [PHYS_REG_BITS-1:0] in_mul_pd_s,
   input  logic [4:0]               in_mul_rd_s,
   input  logic [31:0]              in_mul_rd_v,
   input  logic                     in_div_valid,
   input  logic [ROB_IDX_BITS-1:0]  in_div_rob_idx,
   input  logic [PHYS_REG_BITS-1:0] in_div_pd_s,
   input  logic [4:0]               in_div_rd_s,
   input  logic [31:0]              in_div_rd_v,
   output logic                     add_ready,
   output logic                     mul_ready,
   output logic                     div_ready,
   output logic                     cdb_valid,
   output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
   output logic [PHYS_REG_BITS-1:0] cdb_pd_s,
   output logic [4:0]               cdb_rd_s,
   output logic [31:0]              cdb_rd_v,
   output logic [1:0]               cdb_src,
   output logic                     overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ROB_IDX_BITS + PHYS_REG_BITS + 37;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [EW-1:0] mem [3][DEPTH];
   logic [PW-1:0] wr_ptr [3];
   logic [PW-1:0] rd_ptr [3];
   logic [CW-1:0] cnt [3];
   logic [1:0]    last_grant;
   logic          overflow_q;

   logic [EW-1:0] in_data [3];
   logic [2:0]    in_valid, req, push, pop, drop;
   logic          grant;
   logic [1:0]    winner, o0, o1, o2;
   logic [EW-1:0] head;

   assign in_valid   = {in_div_valid, in_mul_valid, in_add_valid};
   assign in_data[0] = {in_add_rob_idx, in_add_pd_s, in_add_rd_s, in_add_rd_v};
   assign in_data[1] = {in_mul_rob_idx, in_mul_pd_s, in_mul_rd_s, in_mul_rd_v};
   assign in_data[2] = {in_div_rob_idx, in_div_pd_s, in_div_rd_s, in_div_rd_v};

   always_comb begin
      for (int c = 0; c < 3; c++) req[c] = (cnt[c] != '0);
      // Channel after the last winner gets first look; the last winner goes last.
      case (last_grant)
         2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
         2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
         default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
      grant = |req;
      if (req[o0])      winner = o0;
      else if (req[o1]) winner = o1;
      else if (req[o2]) winner = o2;
      else              winner = 2'd0;
      for (int c = 0; c < 3; c++) begin
         pop[c]  = grant && (winner == 2'(c));
         push[c] = in_valid[c] && ((cnt[c] != FULL) || pop[c]);
         drop[c] = in_valid[c] && !push[c];
      end
      case (winner)
         2'd1:    head = mem[1][rd_ptr[1]];
         2'd2:    head = mem[2][rd_ptr[2]];
         default: head = mem[0][rd_ptr[0]];
      endcase
   end

   assign cdb_valid = grant;
   assign {cdb_rob_idx, cdb_pd_s, cdb_rd_s, cdb_rd_v} = grant ? head : '0;
   assign cdb_src   = grant ? winner : 2'd0;
   assign add_ready = (cnt[0] != FULL);
   assign mul_ready = (cnt[1] != FULL);
   assign div_ready = (cnt[2] != FULL);
   assign overflow  = overflow_q;

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         for (int c = 0; c < 3; c++)
            if (push[c]) mem[c][wr_ptr[c]] <= in_data[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            cnt[c]    <= '0;
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
         last_grant <= 2'd2;
         overflow_q <= 1'b0;
      end else if (flush) begin
         for (int c = 0; c < 3; c++) begin
            cnt[c]    <= '0;
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else begin
         if (grant) last_grant <= winner;
         for (int c = 0; c < 3; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
            if (push[c] && !pop[c])      cnt[c] <= cnt[c] + CNT_ONE;
            else if (!push[c] && pop[c]) cnt[c] <= cnt[c] - CNT_ONE;
            if (drop[c]) overflow_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed bench for cdb_arbiter with per-channel expected-result queues
module tb_cdb_arbiter;
   localparam int DEPTH = 4;
   localparam int RB    = 6;
   localparam int PB    = 6;
   localparam int EW    = RB + PB + 37;

   logic clk = 1'b0;
   logic rst, flush;
   logic          in_add_valid, in_mul_valid, in_div_valid;
   logic [RB-1:0] in_add_rob_idx, in_mul_rob_idx, in_div_rob_idx;
   logic [PB-1:0] in_add_pd_s, in_mul_pd_s, in_div_pd_s;
   logic [4:0]    in_add_rd_s, in_mul_rd_s, in_div_rd_s;
   logic [31:0]   in_add_rd_v, in_mul_rd_v, in_div_rd_v;
   logic          add_ready, mul_ready, div_ready;
   logic          cdb_valid, overflow;
   logic [RB-1:0] cdb_rob_idx;
   logic [PB-1:0] cdb_pd_s;
   logic [4:0]    cdb_rd_s;
   logic [31:0]   cdb_rd_v;
   logic [1:0]    cdb_src;

   int n_assert = 0;
   int n_fail   = 0;
   logic [EW-1:0] sbq [3][$];

   cdb_arbiter #(.DEPTH(DEPTH), .ROB_IDX_BITS(RB), .PHYS_REG_BITS(PB)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_add_valid(in_add_valid), .in_add_rob_idx(in_add_rob_idx), .in_add_pd_s(in_add_pd_s),
      .in_add_rd_s(in_add_rd_s), .in_add_rd_v(in_add_rd_v),
      .in_mul_valid(in_mul_valid), .in_mul_rob_idx(in_mul_rob_idx), .in_mul_pd_s(in_mul_pd_s),
      .in_mul_rd_s(in_mul_rd_s), .in_mul_rd_v(in_mul_rd_v),
      .in_div_valid(in_div_valid), .in_div_rob_idx(in_div_rob_idx), .in_div_pd_s(in_div_pd_s),
      .in_div_rd_s(in_div_rd_s), .in_div_rd_v(in_div_rd_v),
      .add_ready(add_ready), .mul_ready(mul_ready), .div_ready(div_ready),
      .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_pd_s(cdb_pd_s),
      .cdb_rd_s(cdb_rd_s), .cdb_rd_v(cdb_rd_v), .cdb_src(cdb_src), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      in_add_valid = 1'b0; in_mul_valid = 1'b0; in_div_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic drive_raw(input int ch, input logic [RB-1:0] rob, input logic [PB-1:0] pd,
                            input logic [4:0] rd, input logic [31:0] v, input bit accept);
      case (ch)
         0: begin in_add_valid = 1'b1; in_add_rob_idx = rob; in_add_pd_s = pd; in_add_rd_s = rd; in_add_rd_v = v; end
         1: begin in_mul_valid = 1'b1; in_mul_rob_idx = rob; in_mul_pd_s = pd; in_mul_rd_s = rd; in_mul_rd_v = v; end
         default: begin in_div_valid = 1'b1; in_div_rob_idx = rob; in_div_pd_s = pd; in_div_rd_s = rd; in_div_rd_v = v; end
      endcase
      if (accept) sbq[ch].push_back({rob, pd, rd, v});
   endtask

   task automatic drive(input int ch, input int i, input logic [31:0] v, input bit accept);
      drive_raw(ch, RB'(ch * 16 + i), PB'(63 - ch * 16 - i), 5'(i * 3 + ch), v, accept);
   endtask

   task automatic observe(input string tag, input bit exp_valid, input int exp_src);
      logic [EW-1:0] e;
      @(negedge clk);
      chk({tag, "_cdb_valid"}, 64'(cdb_valid), 64'(exp_valid));
      if (exp_valid && cdb_valid) begin
         chk({tag, "_cdb_src"}, 64'(cdb_src), 64'(exp_src));
         n_assert++;
         assert (cdb_src < 2'd3 && sbq[cdb_src].size() != 0) else begin
            n_fail++;
            $error("FAIL %s_unexpected_result: observed src %0d, expected a queued entry", tag, cdb_src);
         end
         if (cdb_src < 2'd3 && sbq[cdb_src].size() != 0) begin
            e = sbq[cdb_src].pop_front();
            chk({tag, "_cdb_entry"}, 64'({cdb_rob_idx, cdb_pd_s, cdb_rd_s, cdb_rd_v}), 64'(e));
         end
      end else if (!exp_valid) begin
         chk({tag, "_cdb_idle_fields"},
             64'({cdb_src, cdb_rob_idx, cdb_pd_s, cdb_rd_s, cdb_rd_v}), 64'd0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      for (int c = 0; c < 3; c++) sbq[c].delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Reset, then all three channels at once: add first, then mul, then div
      do_reset();
      drive_raw(0, 6'd1, 6'd11, 5'd1, 32'h1, 1'b1);
      drive_raw(1, 6'd2, 6'd12, 5'd2, 32'h2, 1'b1);
      drive_raw(2, 6'd3, 6'd13, 5'd3, 32'h3, 1'b1);
      observe("reset", 1'b0, 0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_ready", 64'({add_ready, mul_ready, div_ready}), 64'(3'b111));
      next_cycle();
      for (int c = 1; c <= 4; c++) begin
         observe("simul", c <= 3, c - 1);
         next_cycle();
      end

      // Single add result
      do_reset();
      drive_raw(0, 6'd5, 6'd12, 5'd3, 32'hDEADBEEF, 1'b1);
      observe("single_c0", 1'b0, 0);
      next_cycle();
      observe("single_c1", 1'b1, 0);
      next_cycle();
      observe("single_c2", 1'b0, 0);
      next_cycle();

      // add and mul both streaming: grants alternate, FIFO order preserved
      do_reset();
      for (int c = 0; c <= 13; c++) begin
         if (c < 6) begin
            drive(0, c, 32'h100 + 32'(c), 1'b1);
            drive(1, c, 32'(c), 1'b1);
         end
         observe("rr", c >= 1 && c <= 12, (c % 2 == 1) ? 0 : 1);
         if (c < 6) chk("rr_mul_ready", 64'(mul_ready), 64'd1);
         chk("rr_overflow", 64'(overflow), 64'd0);
         next_cycle();
      end

      // All three streaming for DEPTH+2 cycles: div fills and its sixth entry is dropped;
      // mul is full in cycle 5 but popped that cycle, so its entry is accepted.
      do_reset();
      for (int c = 0; c <= 18; c++) begin
         if (c < 6) begin
            drive(0, c, 32'hA000 + 32'(c), 1'b1);
            drive(1, c, 32'hB000 + 32'(c), 1'b1);
            drive(2, c, 32'hC000 + 32'(c), c != 5);
         end
         observe("ovf", c >= 1 && c <= 17, (c + 2) % 3);
         if (c == 4) chk("ovf_div_ready_c4", 64'(div_ready), 64'd1);
         if (c == 5) chk("ovf_div_ready_c5", 64'(div_ready), 64'd0);
         if (c == 6) chk("ovf_ready_c6", 64'({add_ready, mul_ready, div_ready}), 64'(3'b000));
         chk("ovf_overflow", 64'(overflow), 64'(c >= 6));
         next_cycle();
      end

      // Flush with a backlog and a same-cycle mul input
      do_reset();
      for (int c = 0; c <= 7; c++) begin
         if (c < 3) begin
            drive(0, c, 32'hD000 + 32'(c), 1'b1);
            drive(1, c, 32'hE000 + 32'(c), 1'b1);
         end
         if (c == 3) begin
            flush = 1'b1;
            drive(1, 7, 32'hBAD0, 1'b0);
         end
         observe("flush", c >= 1 && c <= 3, (c == 2) ? 1 : 0);
         if (c == 3) for (int k = 0; k < 3; k++) sbq[k].delete();
         if (c == 4) chk("flush_ready", 64'({add_ready, mul_ready, div_ready}), 64'(3'b111));
         chk("flush_overflow", 64'(overflow), 64'd0);
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
